// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter generator.
//   pc_state_e        : FSM encoding driven onto the 2-bit state output
//                       (RUN=0, HOLD=1, TRAP=2).
//   PC_RESET_VEC_DFLT : default PC after reset.
//   PC_EXC_VEC_DFLT   : default exception handler address.
//   PC_STEP_DFLT      : default sequential increment in bytes.
package pc_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      TRAP = 2'd2
   } pc_state_e;

   localparam logic [31:0] PC_RESET_VEC_DFLT = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC_DFLT   = 32'h0000_4180;
   localparam int          PC_STEP_DFLT      = 4;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if -- request/result bundle between the fetch control and pc_gen.
//   Requests (master -> slave): loadad (stall), jr + busAtoMe (register
//   jump), br_taken + topc (branch), exc (exception), eret (return).
//   Results  (slave -> master): toIU (current PC), pc_plus (toIU + STEP),
//   flush, addr_err, epc (saved exception PC), state (FSM state).
interface pc_gen_if #(
   parameter int WIDTH = 32
);

   logic             loadad;
   logic             jr;
   logic [WIDTH-1:0] busAtoMe;
   logic             br_taken;
   logic [WIDTH-1:0] topc;
   logic             exc;
   logic             eret;

   logic [WIDTH-1:0] toIU;
   logic [WIDTH-1:0] pc_plus;
   logic             flush;
   logic             addr_err;
   logic [WIDTH-1:0] epc;
   logic [1:0]       state;

   modport master (
      output loadad, jr, busAtoMe, br_taken, topc, exc, eret,
      input  toIU, pc_plus, flush, addr_err, epc, state
   );

   modport slave (
      input  loadad, jr, busAtoMe, br_taken, topc, exc, eret,
      output toIU, pc_plus, flush, addr_err, epc, state
   );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel -- combinational next-PC priority selector for pc_gen.
//   Priority: exc > eret > loadad (hold) > jr > br_taken > sequential.
//   Inputs : state, pc (current), pc_plus, epc, and the request signals.
//   Outputs: nxt_pc, redirect (a non-sequential target is loaded),
//            trap_take (edge enters TRAP), eret_take, epc_save
//            (capture pc into epc), addr_err_nxt (misaligned jr).
// Build option: PC_GEN_EXC_EN enables exception/trap handling. Without it
// exc/eret are ignored and a misaligned jr target is word-aligned instead.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(PC_EXC_VEC_DFLT)
) (
   input  pc_state_e        state,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] pc_plus,
   input  logic [WIDTH-1:0] epc,
   input  logic             loadad,
   input  logic             jr,
   input  logic [WIDTH-1:0] busAtoMe,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] topc,
   input  logic             exc,
   input  logic             eret,
   output logic [WIDTH-1:0] nxt_pc,
   output logic             redirect,
   output logic             trap_take,
   output logic             eret_take,
   output logic             epc_save,
   output logic             addr_err_nxt
);

   logic misal;

   assign misal = jr && (busAtoMe[1:0] != 2'b00);

`ifdef PC_GEN_EXC_EN
   always_comb begin
      nxt_pc       = pc;
      redirect     = 1'b0;
      trap_take    = 1'b0;
      eret_take    = 1'b0;
      epc_save     = 1'b0;
      addr_err_nxt = 1'b0;
      if (exc) begin
         // A nested exception keeps the epc of the first one.
         nxt_pc    = EXC_VEC;
         redirect  = 1'b1;
         trap_take = 1'b1;
         epc_save  = (state != TRAP);
      end else if (state == TRAP) begin
         // Handler entry is held for the TRAP cycle; other requests wait.
         nxt_pc = EXC_VEC;
      end else if (eret) begin
         nxt_pc    = epc;
         redirect  = 1'b1;
         eret_take = 1'b1;
      end else if (loadad) begin
         nxt_pc = pc;
      end else if (jr) begin
         if (misal) begin
            // Misaligned register target is promoted to an exception.
            nxt_pc       = EXC_VEC;
            redirect     = 1'b1;
            trap_take    = 1'b1;
            epc_save     = 1'b1;
            addr_err_nxt = 1'b1;
         end else begin
            nxt_pc   = busAtoMe;
            redirect = 1'b1;
         end
      end else if (br_taken) begin
         nxt_pc   = topc;
         redirect = 1'b1;
      end else begin
         nxt_pc = pc_plus;
      end
   end
`else
   logic unused_exc;

   assign unused_exc = ^{state, epc, exc, eret, EXC_VEC};

   always_comb begin
      nxt_pc       = pc;
      redirect     = 1'b0;
      trap_take    = 1'b0;
      eret_take    = 1'b0;
      epc_save     = 1'b0;
      addr_err_nxt = 1'b0;
      if (loadad) begin
         nxt_pc = pc;
      end else if (jr) begin
         // Misaligned target: flag it but still jump to the aligned word.
         nxt_pc       = {busAtoMe[WIDTH-1:2], 2'b00};
         redirect     = 1'b1;
         addr_err_nxt = misal;
      end else if (br_taken) begin
         nxt_pc   = topc;
         redirect = 1'b1;
      end else begin
         nxt_pc = pc_plus;
      end
   end
`endif

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator with stall, jumps, branches and
// exception entry/return. All state updates on the falling clock edge;
// reset is asynchronous and active-high.
//   clk, reset : clock (falling-edge active) and async reset.
//   bus        : pc_gen_if.slave carrying requests (loadad, jr, busAtoMe,
//                br_taken, topc, exc, eret) and results (toIU, pc_plus,
//                flush, addr_err, epc, state).
// Build option: PC_GEN_EXC_EN enables exception support (epc, TRAP state,
// eret, misaligned jr as exception). Without it epc stays 0 and TRAP is
// never entered.
module pc_gen
   import pc_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DFLT),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC_DFLT),
   parameter int               STEP      = PC_STEP_DFLT
) (
   input  logic    clk,
   input  logic    reset,
   pc_gen_if.slave bus
);

   pc_state_e        state_p0;
   logic [WIDTH-1:0] pc_p0;
   logic [WIDTH-1:0] epc_p0;
   logic             flush_p0;
   logic             addr_err_p0;

   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] nxt_pc;
   logic             redirect;
   logic             trap_take;
   logic             eret_take;
   logic             epc_save;
   logic             addr_err_nxt;

   // Natural wrap modulo 2^WIDTH.
   assign pc_plus = pc_p0 + WIDTH'(STEP);

   pc_next_sel #(
      .WIDTH   (WIDTH),
      .EXC_VEC (EXC_VEC)
   ) u_sel (
      .state        (state_p0),
      .pc           (pc_p0),
      .pc_plus      (pc_plus),
      .epc          (epc_p0),
      .loadad       (bus.loadad),
      .jr           (bus.jr),
      .busAtoMe     (bus.busAtoMe),
      .br_taken     (bus.br_taken),
      .topc         (bus.topc),
      .exc          (bus.exc),
      .eret         (bus.eret),
      .nxt_pc       (nxt_pc),
      .redirect     (redirect),
      .trap_take    (trap_take),
      .eret_take    (eret_take),
      .epc_save     (epc_save),
      .addr_err_nxt (addr_err_nxt)
   );

`ifndef PC_GEN_EXC_EN
   logic unused_epc_save;

   assign unused_epc_save = epc_save;
`endif

   // Stage p0: PC, epc, pulse outputs and FSM, all updated on the falling edge.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         pc_p0       <= RESET_VEC;
         epc_p0      <= '0;
         flush_p0    <= 1'b0;
         addr_err_p0 <= 1'b0;
         state_p0    <= RUN;
      end else begin
         pc_p0       <= nxt_pc;
         flush_p0    <= redirect;
         addr_err_p0 <= addr_err_nxt;
`ifdef PC_GEN_EXC_EN
         if (epc_save) begin
            epc_p0 <= pc_p0;
         end
`endif
         case (state_p0)
            TRAP: begin
               state_p0 <= trap_take ? TRAP : RUN;
            end
            default: begin
               if (trap_take) begin
                  state_p0 <= TRAP;
               end else if (eret_take) begin
                  state_p0 <= RUN;
               end else if (bus.loadad) begin
                  state_p0 <= HOLD;
               end else begin
                  state_p0 <= RUN;
               end
            end
         endcase
      end
   end

   assign bus.toIU     = pc_p0;
   assign bus.pc_plus  = pc_plus;
   assign bus.flush    = flush_p0;
   assign bus.addr_err = addr_err_p0;
   assign bus.epc      = epc_p0;
   assign bus.state    = state_p0;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- table-driven bench for pc_gen with a scoreboard queue.
// A 32-bit instance runs the main vector table; an 8-bit instance with
// reset vector 8'hFC exercises the increment wrap.
module tb_pc_gen;
   import pc_pkg::*;

   typedef struct {
      logic        ld;
      logic        jr;
      logic [31:0] ba;
      logic        br;
      logic [31:0] tp;
      logic        ex;
      logic        er;
      logic [31:0] e_pc;
      logic        e_fl;
      logic        e_ae;
      logic [31:0] e_epc;
      logic [1:0]  e_st;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        fl;
      logic        ae;
      logic [31:0] epc;
      logic [1:0]  st;
   } exp_t;

   logic clk;
   logic reset;
   logic rst8;

   int passed;
   int total;

   vec_t vecs[$];
   exp_t sb[$];

   pc_gen_if #(.WIDTH(32)) bus ();
   pc_gen_if #(.WIDTH(8))  bus8 ();

   pc_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pc_gen #(
      .WIDTH     (8),
      .RESET_VEC (8'hFC),
      .EXC_VEC   (8'h80),
      .STEP      (4)
   ) dut8 (
      .clk   (clk),
      .reset (rst8),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1, "bench timeout");
   end

   function automatic vec_t mk(input logic ld, input logic jr, input logic [31:0] ba,
                               input logic br, input logic [31:0] tp,
                               input logic ex, input logic er,
                               input logic [31:0] e_pc, input logic e_fl,
                               input logic e_ae, input logic [31:0] e_epc,
                               input logic [1:0] e_st);
      vec_t v;
      v.ld = ld; v.jr = jr; v.ba = ba; v.br = br; v.tp = tp; v.ex = ex; v.er = er;
      v.e_pc = e_pc; v.e_fl = e_fl; v.e_ae = e_ae; v.e_epc = e_epc; v.e_st = e_st;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   task automatic drive(input vec_t v, input int id);
      exp_t e;
      bus.loadad   = v.ld;
      bus.jr       = v.jr;
      bus.busAtoMe = v.ba;
      bus.br_taken = v.br;
      bus.topc     = v.tp;
      bus.exc      = v.ex;
      bus.eret     = v.er;
      e.id = id; e.pc = v.e_pc; e.fl = v.e_fl; e.ae = v.e_ae; e.epc = v.e_epc; e.st = v.e_st;
      sb.push_back(e);
   endtask

   task automatic settle_and_check();
      exp_t e;
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sb.pop_front();
         chk($sformatf("v%0d toIU", e.id),     bus.toIU,              e.pc);
         chk($sformatf("v%0d pc_plus", e.id),  bus.pc_plus,           e.pc + 32'd4);
         chk($sformatf("v%0d flush", e.id),    32'(bus.flush),        32'(e.fl));
         chk($sformatf("v%0d addr_err", e.id), 32'(bus.addr_err),     32'(e.ae));
         chk($sformatf("v%0d epc", e.id),      bus.epc,               e.epc);
         chk($sformatf("v%0d state", e.id),    32'(bus.state),        32'(e.st));
      end
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b1;
      rst8   = 1'b1;
      drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, RUN), -1);
      void'(sb.pop_front());
      bus8.loadad = 1'b0; bus8.jr = 1'b0; bus8.busAtoMe = 8'h00; bus8.br_taken = 1'b0;
      bus8.topc = 8'h00; bus8.exc = 1'b0; bus8.eret = 1'b0;

      // Sequential, stall and redirect priority.
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h3004, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h3008, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h300C, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(1, 0, 32'h0,    0, 32'h0,    0, 0, 32'h300C, 0, 0, 32'h0, HOLD));
      vecs.push_back(mk(1, 0, 32'h0,    0, 32'h0,    0, 0, 32'h300C, 0, 0, 32'h0, HOLD));
      vecs.push_back(mk(1, 1, 32'h5000, 1, 32'h6000, 0, 0, 32'h300C, 0, 0, 32'h0, HOLD));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h3010, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 1, 32'h5000, 1, 32'h6000, 0, 0, 32'h5000, 1, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h5004, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    1, 32'h6000, 0, 0, 32'h6000, 1, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0,    0, 0, 32'h6004, 0, 0, 32'h0, RUN));
`ifdef PC_GEN_EXC_EN
      // Misaligned jr as exception, exception under stall, nested trap, eret.
      vecs.push_back(mk(0, 1, 32'h5002, 0, 32'h0, 0, 0, 32'h4180, 1, 1, 32'h6004, TRAP));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 0, 0, 32'h4180, 0, 0, 32'h6004, RUN));
      vecs.push_back(mk(0, 1, 32'h3010, 0, 32'h0, 0, 0, 32'h3010, 1, 0, 32'h6004, RUN));
      vecs.push_back(mk(1, 0, 32'h0,    0, 32'h0, 0, 0, 32'h3010, 0, 0, 32'h6004, HOLD));
      vecs.push_back(mk(1, 0, 32'h0,    0, 32'h0, 1, 0, 32'h4180, 1, 0, 32'h3010, TRAP));
      vecs.push_back(mk(1, 1, 32'h5000, 0, 32'h0, 0, 0, 32'h4180, 0, 0, 32'h3010, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 0, 1, 32'h3010, 1, 0, 32'h3010, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 0, 0, 32'h3014, 0, 0, 32'h3010, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 1, 0, 32'h4180, 1, 0, 32'h3014, TRAP));
      vecs.push_back(mk(0, 1, 32'h5000, 0, 32'h0, 1, 0, 32'h4180, 1, 0, 32'h3014, TRAP));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 0, 0, 32'h4180, 0, 0, 32'h3014, RUN));
      vecs.push_back(mk(1, 0, 32'h0,    0, 32'h0, 0, 1, 32'h3014, 1, 0, 32'h3014, RUN));
      vecs.push_back(mk(0, 1, 32'h7000, 0, 32'h0, 0, 0, 32'h7000, 1, 0, 32'h3014, RUN));
`else
      // Misaligned jr is aligned; exc/eret have no effect.
      vecs.push_back(mk(0, 1, 32'h5002, 0, 32'h0, 0, 0, 32'h5000, 1, 1, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 0, 0, 32'h5004, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(0, 0, 32'h0,    0, 32'h0, 1, 1, 32'h5008, 0, 0, 32'h0, RUN));
      vecs.push_back(mk(1, 0, 32'h0,    0, 32'h0, 1, 0, 32'h5008, 0, 0, 32'h0, HOLD));
      vecs.push_back(mk(0, 1, 32'h7000, 0, 32'h0, 0, 0, 32'h7000, 1, 0, 32'h0, RUN));
`endif

      // Reset values of both instances.
      @(posedge clk);
      chk("rst toIU",     bus.toIU,            32'h0000_3000);
      chk("rst state",    32'(bus.state),      32'(RUN));
      chk("rst epc",      bus.epc,             32'h0);
      chk("rst flush",    32'(bus.flush),      32'h0);
      chk("rst addr_err", 32'(bus.addr_err),   32'h0);
      chk("rst8 toIU",    32'(bus8.toIU),      32'hFC);
      chk("rst8 pc_plus", 32'(bus8.pc_plus),   32'h00);

      // Wrap on the 8-bit instance: FC -> 00 after one free edge.
      rst8 = 1'b0;
      @(negedge clk);
      #1;
      chk("wrap8 toIU",    32'(bus8.toIU),    32'h00);
      chk("wrap8 flush",   32'(bus8.flush),   32'h0);
      chk("wrap8 pc_plus", 32'(bus8.pc_plus), 32'h04);

      @(posedge clk);
      rst8  = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i], i);
         settle_and_check();
         @(posedge clk);
      end

      // Asynchronous reset mid-run, after a flush-producing jump.
      #2;
      reset = 1'b1;
      #1;
      chk("midrst toIU",     bus.toIU,          32'h0000_3000);
      chk("midrst state",    32'(bus.state),    32'(RUN));
      chk("midrst epc",      bus.epc,           32'h0);
      chk("midrst flush",    32'(bus.flush),    32'h0);
      chk("midrst addr_err", 32'(bus.addr_err), 32'h0);

      // Reset overrides requests across an edge, then release mid-stall.
      drive(mk(1, 1, 32'h9000, 1, 32'hA000, 1, 1, 32'h3000, 0, 0, 32'h0, RUN), 100);
      settle_and_check();
      @(posedge clk);
      reset = 1'b0;
      drive(mk(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h3000, 0, 0, 32'h0, HOLD), 101);
      settle_and_check();
      @(posedge clk);
      drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h3004, 0, 0, 32'h0, RUN), 102);
      settle_and_check();

      if (sb.size() != 0) begin
         total++;
         $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL parameter WIDTH, 32, PC and target width in bits (minimum 8).
REQ-002 SHALL parameter RESET_VEC, 32'h0000_3000, PC value loaded by reset.
REQ-003 SHALL parameter EXC_VEC, 32'h0000_4180, exception handler address.
REQ-004 SHALL parameter STEP, 4, sequential increment in bytes.
REQ-005 SHALL port clk  input  1  clock; all state updates on the falling edge.
REQ-006 SHALL port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL port loadad  input  1  stall; holds PC while high.
REQ-008 SHALL port jr  input  1  register-indirect jump request.
REQ-009 SHALL port busAtoMe  input  WIDTH  register jump target.
REQ-010 SHALL port br_taken  input  1  branch/jump redirect request.
REQ-011 SHALL port topc  input  WIDTH  branch/jump target.
REQ-012 SHALL port exc  input  1  exception request.
REQ-013 SHALL port eret  input  1  exception-return request.
REQ-014 SHALL port toIU  output  WIDTH  current PC to instruction unit.
REQ-015 SHALL port pc_plus  output  WIDTH  toIU + STEP, combinational, modulo 2^WIDTH.
REQ-016 SHALL port flush  output  1  one-cycle pulse after any non-sequential PC load.
REQ-017 SHALL port addr_err  output  1  one-cycle pulse on misaligned jr target.
REQ-018 SHALL port epc  output  WIDTH  saved exception PC.
REQ-019 SHALL port state  output  2  FSM state (RUN=0, HOLD=1, TRAP=2).

Function
REQ-020 SHALL select next PC by priority: exc > eret > loadad (hold) > jr > br_taken > sequential toIU+STEP.
REQ-021 SHALL apply exc and eret even while loadad is high.
REQ-022 SHALL, on exc, load EXC_VEC and capture current toIU into epc in the same edge.
REQ-023 SHALL, on eret, load epc into the PC; epc itself unchanged.
REQ-024 SHALL, on jr with busAtoMe[1:0] != 0, not load busAtoMe; instead pulse addr_err and treat the edge as exc (load EXC_VEC, epc <= toIU).
REQ-025 SHALL wrap sequential increment modulo 2^WIDTH (all-ones-minus-3 -> 0 with STEP=4).
REQ-026 SHALL assert flush for exactly one cycle following each edge that loaded jr, br, exc, or eret target; never for sequential or hold.
REQ-027 SHALL run FSM: RUN->HOLD when loadad and no exc/eret; HOLD->RUN when loadad low; any->TRAP on exc or addr_err; TRAP->RUN unconditionally next edge, PC held at EXC_VEC during TRAP regardless of loadad.
REQ-028 SHALL, in TRAP, ignore jr/br_taken; a second exc in TRAP re-enters TRAP without overwriting epc.
REQ-029 SHALL have single-cycle latency: request sampled at edge N appears on toIU after edge N.

Reset
REQ-030 SHALL on reset drive toIU=RESET_VEC, epc=0, flush=0, addr_err=0, state=RUN, independent of clk.
REQ-031 SHALL have reset override all requests; release mid-stall resumes in HOLD/RUN per loadad at next edge.

Configuration
REQ-032 SHALL compile exception support under macro PC_GEN_EXC_EN.
REQ-033 SHALL with PC_GEN_EXC_EN defined implement REQ-022..REQ-024, REQ-027..REQ-028 in full.
REQ-034 SHALL without PC_GEN_EXC_EN ignore exc/eret, tie epc to 0, never enter TRAP, and on misaligned jr pulse addr_err and load busAtoMe with bits [1:0] cleared.

Structure
REQ-035 SHALL place FSM state encoding (RUN/HOLD/TRAP) and default RESET_VEC/EXC_VEC constants in shared package pc_pkg.
REQ-036 SHALL isolate next-PC priority mux in sub-module pc_next_sel (combinational); state, epc, flush registers in pc_gen.

Verification
REQ-037 SHALL test reset: assert reset mid-run -> toIU=32'h0000_3000 immediately, state=RUN, epc=0.
REQ-038 SHALL test sequential+stall: 3 free edges then loadad=1 for 2 edges -> toIU 3000,3004,3008,300C,300C,300C, state HOLD, flush never high.
REQ-039 SHALL test priority: jr=1 busAtoMe=0x5000, br_taken=1 topc=0x6000, loadad=0 -> toIU=0x5000, flush high one cycle.
REQ-040 SHALL test exception under stall: toIU=0x3010, loadad=1, exc=1 -> toIU=0x4180, epc=0x3010, state TRAP then RUN; eret -> toIU=0x3010, flush pulse.
REQ-041 SHALL test misaligned jr: busAtoMe=0x5002 -> addr_err pulse, toIU=0x4180 (with macro) or 0x5000 (without).
REQ-042 SHALL test wrap: WIDTH=8, RESET_VEC=8'hFC, one free edge -> toIU=8'h00, no flush.
